// File: rtl/decode_issue_queue_if.sv
// decode_issue_queue_if
//   Fetch-side and execute-side handshake bundle of the decode issue queue.
//   in_*  : fetch -> queue entry push (valid/ready)
//   out_* : queue -> execute issue (valid/ready) with class and AMO phase
//   master: driven by fetch/execute (the environment); slave: the queue itself.
interface decode_issue_queue_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic [2:0]      out_class;
    logic [1:0]      out_phase;

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_class, out_phase
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_class, out_phase
    );
endinterface

// File: rtl/decode_issue_queue.sv
// decode_issue_queue
//   DEPTH-entry {pc,instr} FIFO between fetch and execute. Classifies the head
//   entry and issues it; MUL/DIV blocks issue until muldiv_done, read-modify-write
//   AMOs issue twice (read phase, then write phase) before the entry is popped.
// Ports
//   CLK, nRST    : clock (rising edge), async active-low reset
//   flush        : sync flush, drops all entries and aborts sequencing
//   bus          : slave side of decode_issue_queue_if (push and issue handshakes)
//   muldiv_done  : completion pulse from the MUL/DIV unit
//   busy         : sequencer is waiting on MUL/DIV or in the AMO write phase
//   count        : occupied entries
module decode_issue_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     flush,
    decode_issue_queue_if.slave      bus,
    input  logic                     muldiv_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    localparam logic [2:0] C_ALU = 3'd0, C_BRANCH = 3'd1, C_LOAD = 3'd2, C_STORE = 3'd3,
                           C_MULDIV = 3'd4, C_AMO = 3'd5, C_SYSTEM = 3'd6, C_ILLEGAL = 3'd7;

    typedef enum logic [1:0] {ISSUE, WAIT_MD, AMO_ST} state_t;

    state_t          state_q;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PW:0]     count_q;
    logic [XLEN-1:0] pc_mem_q  [DEPTH];
    logic [31:0]     ins_mem_q [DEPTH];

    logic [XLEN-1:0] head_pc;
    logic [31:0]     head_ins;
    logic [2:0]      head_cls;
    logic            head_rmw;
    logic            empty, full, push, pop, fire;

    assign head_pc  = pc_mem_q[rd_ptr_q];
    assign head_ins = ins_mem_q[rd_ptr_q];

    always_comb begin
        head_cls = C_ILLEGAL;
        unique case (head_ins[6:0])
            7'b0110011: head_cls = (head_ins[31:25] == 7'b0000001) ? C_MULDIV : C_ALU;
            7'b0010011,
            7'b0110111,
            7'b0010111: head_cls = C_ALU;
            7'b1101111,
            7'b1100111,
            7'b1100011: head_cls = C_BRANCH;
            7'b0000011: head_cls = C_LOAD;
            7'b0100011: head_cls = C_STORE;
            7'b0101111: head_cls = (head_ins[14:12] == 3'b010) ? C_AMO : C_ILLEGAL;
            7'b1110011,
            7'b0001111: head_cls = C_SYSTEM;
            default:    head_cls = C_ILLEGAL;
        endcase
    end

    // LR/SC are plain single-phase memory ops; every other AMO is read then write.
    assign head_rmw = (head_cls == C_AMO) && (head_ins[31:27] != 5'b00010)
                                          && (head_ins[31:27] != 5'b00011);

    assign empty = (count_q == '0);
    assign full  = (count_q == (PW+1)'(DEPTH));

    assign bus.in_ready  = !full;
    assign bus.out_valid = ((state_q == ISSUE) && !empty) || (state_q == AMO_ST);
    assign bus.out_pc    = head_pc;
    assign bus.out_instr = head_ins;
    assign bus.out_class = head_cls;
    assign bus.out_phase = (state_q == AMO_ST)              ? 2'b10 :
                           ((state_q == ISSUE) && head_rmw) ? 2'b01 : 2'b00;

    assign busy  = (state_q != ISSUE);
    assign count = count_q;

    assign push = bus.in_valid && !full;
    assign fire = bus.out_valid && bus.out_ready;
    // The AMO read phase keeps the entry at the head for its write phase.
    assign pop  = fire && ((state_q == AMO_ST) || !head_rmw);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= ISSUE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            state_q  <= ISSUE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            unique case (state_q)
                ISSUE: begin
                    if (fire && head_cls == C_MULDIV) state_q <= WAIT_MD;
                    else if (fire && head_rmw)        state_q <= AMO_ST;
                end
                WAIT_MD: if (muldiv_done) state_q <= ISSUE;
                AMO_ST:  if (fire)        state_q <= ISSUE;
                default: state_q <= ISSUE;
            endcase
        end
    end

    // Storage needs no reset: contents are only observed while out_valid=1.
    always_ff @(posedge CLK) begin
        if (push && !flush) begin
            pc_mem_q[wr_ptr_q]  <= bus.in_pc;
            ins_mem_q[wr_ptr_q] <= bus.in_instr;
        end
    end
endmodule

// File: tb/tb_decode_issue_queue.sv
module tb_decode_issue_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [2:0]  cls;
        logic [1:0]  phase;
    } ent_t;

    logic CLK = 1'b0;
    logic nRST, flush, muldiv_done, busy;
    logic [$clog2(DEPTH):0] count;

    decode_issue_queue_if #(.XLEN(XLEN)) bus ();

    decode_issue_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush), .bus(bus),
        .muldiv_done(muldiv_done), .busy(busy), .count(count)
    );

    always #5 CLK = ~CLK;

    int   total = 0, bad = 0;
    ent_t sb[$];
    logic [2:0] cur_cls;
    logic       cur_rmw;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                          input logic [2:0] cls, input logic rmw);
        bus.in_valid = v; bus.in_pc = pc; bus.in_instr = ins;
        cur_cls = cls; cur_rmw = rmw;
    endtask

    // One cycle: settle, score issue/push as the DUT will see them at the edge.
    task automatic tick();
        ent_t e;
        #1;
        if (flush) sb.delete();
        else begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) chk("issue_unexpected", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("out_pc", bus.out_pc, e.pc);
                    chk("out_instr", bus.out_instr, e.instr);
                    chk("out_class", bus.out_class, e.cls);
                    chk("out_phase", bus.out_phase, e.phase);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e.pc = bus.in_pc; e.instr = bus.in_instr; e.cls = cur_cls;
                e.phase = cur_rmw ? 2'b01 : 2'b00;
                sb.push_back(e);
                if (cur_rmw) begin e.phase = 2'b10; sb.push_back(e); end
            end
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic push1(input logic [31:0] pc, input logic [31:0] ins,
                         input logic [2:0] cls, input logic rmw);
        set_in(1'b1, pc, ins, cls, rmw);
        tick();
        set_in(1'b0, 0, 0, 0, 1'b0);
    endtask

    logic [31:0] tbl_ins [8];
    logic [2:0]  tbl_cls [8];
    int k;
    logic acc;

    initial begin
        tbl_ins = '{32'h00500093, 32'h002081B3, 32'h0000A103, 32'h0020A023,
                    32'h00208063, 32'h0000006F, 32'h00000073, 32'h000000B7};
        tbl_cls = '{3'd0, 3'd0, 3'd2, 3'd3, 3'd1, 3'd1, 3'd6, 3'd0};
        nRST = 1'b0; flush = 1'b0; muldiv_done = 1'b0; bus.out_ready = 1'b0;
        set_in(1'b0, 0, 0, 0, 1'b0);
        #3;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        chk("rst_phase", bus.out_phase, 0);
        @(negedge CLK);
        nRST = 1'b1;

        // single ADDI, 1-cycle push->valid latency
        push1(32'h100, 32'h00500093, 3'd0, 1'b0);
        chk("addi_valid", bus.out_valid, 1);
        chk("addi_class", bus.out_class, 0);
        chk("addi_phase", bus.out_phase, 0);
        chk("addi_count", count, 1);
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
        chk("addi_drained", count, 0);

        // fill, then streaming push/pop with pointer wrap
        for (int i = 0; i < 4; i++) push1(32'h200 + 4*i, tbl_ins[i], tbl_cls[i], 1'b0);
        chk("full_in_ready", bus.in_ready, 0);
        chk("full_count", count, 4);
        bus.out_ready = 1'b1;
        k = 4;
        for (int c = 0; c < 6; c++) begin
            set_in(1'b1, 32'h200 + 4*k, tbl_ins[k%8], tbl_cls[k%8], 1'b0);
            acc = bus.in_ready;
            tick();
            if (acc) k++;
        end
        set_in(1'b0, 0, 0, 0, 1'b0);
        chk("stream_accepts", k, 9);
        for (int c = 0; c < 10 && count != 0; c++) tick();
        chk("stream_drain_count", count, 0);
        chk("stream_sb_empty", sb.size(), 0);
        bus.out_ready = 1'b0;

        // MUL blocks issue until muldiv_done
        push1(32'h300, 32'h022081B3, 3'd4, 1'b0);
        push1(32'h304, 32'h00500093, 3'd0, 1'b0);
        bus.out_ready = 1'b1; tick();
        chk("md_busy", busy, 1);
        chk("md_valid", bus.out_valid, 0);
        push1(32'h308, 32'h0000A103, 3'd2, 1'b0);
        chk("md_push_count", count, 2);
        for (int c = 0; c < 4; c++) tick();
        chk("md_still_wait", bus.out_valid, 0);
        muldiv_done = 1'b1; tick(); muldiv_done = 1'b0;
        chk("md_done_busy", busy, 0);
        chk("md_done_valid", bus.out_valid, 1);
        chk("md_next_pc", bus.out_pc, 32'h304);
        tick(); tick();
        chk("md_drained", count, 0);
        bus.out_ready = 1'b0;

        // AMOADD.W two phases, then LR.W single
        push1(32'h400, 32'h0020A1AF, 3'd5, 1'b1);
        chk("amo_rd_phase", bus.out_phase, 2'b01);
        bus.out_ready = 1'b1; tick();
        chk("amo_busy", busy, 1);
        chk("amo_wr_phase", bus.out_phase, 2'b10);
        chk("amo_same_pc", bus.out_pc, 32'h400);
        chk("amo_not_popped", count, 1);
        tick();
        chk("amo_popped", count, 0);
        chk("amo_idle", busy, 0);
        bus.out_ready = 1'b0;
        push1(32'h404, 32'h1000A1AF, 3'd5, 1'b0);
        chk("lr_phase", bus.out_phase, 2'b00);
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
        chk("lr_single", count, 0);
        chk("lr_idle", busy, 0);

        // flush while in AMO_ST with pending push
        push1(32'h500, 32'h0020A1AF, 3'd5, 1'b1);
        push1(32'h504, 32'h00500093, 3'd0, 1'b0);
        push1(32'h508, 32'h00500093, 3'd0, 1'b0);
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
        chk("fl_pre_count", count, 3);
        chk("fl_pre_busy", busy, 1);
        set_in(1'b1, 32'h50C, 32'h00500093, 3'd0, 1'b0);
        flush = 1'b1; tick(); flush = 1'b0;
        set_in(1'b0, 0, 0, 0, 1'b0);
        chk("fl_count", count, 0);
        chk("fl_valid", bus.out_valid, 0);
        chk("fl_busy", busy, 0);

        // illegal encodings issue once as single-phase
        push1(32'h600, 32'h0000007F, 3'd7, 1'b0);
        chk("ill_class", bus.out_class, 7);
        push1(32'h604, 32'h0000802F, 3'd7, 1'b0);
        bus.out_ready = 1'b1; tick(); tick(); bus.out_ready = 1'b0;
        chk("ill_count", count, 0);
        chk("ill_valid", bus.out_valid, 0);
        chk("ill_sb_empty", sb.size(), 0);

        // async reset in WAIT_MD
        push1(32'h700, 32'h022081B3, 3'd4, 1'b0);
        push1(32'h704, 32'h00500093, 3'd0, 1'b0);
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
        chk("ar_pre_busy", busy, 1);
        #2 nRST = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_valid", bus.out_valid, 0);
        chk("ar_count", count, 0);
        chk("ar_in_ready", bus.in_ready, 1);
        chk("ar_phase", bus.out_phase, 0);
        sb.delete();
        @(negedge CLK);
        nRST = 1'b1;
        tick();
        chk("ar_after_valid", bus.out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
